// File: rtl/commit_trace_if.sv
// Writeback tap and trace drain stream for commit_trace_buffer.
// The master side drives retirements and the drain ready; the slave side is the recorder.
interface commit_trace_if #(
    parameter int PC_W   = 16,
    parameter int DATA_W = 16,
    parameter int CYC_W  = 16
);
    logic              wb_valid;
    logic [PC_W-1:0]   wb_pc;
    logic [PC_W-1:0]   wb_instr;
    logic [DATA_W-1:0] wb_data;
    logic              wb_halt;

    logic              rd_ready;
    logic              rd_valid;
    logic [CYC_W-1:0]  rd_cyc;
    logic [PC_W-1:0]   rd_pc;
    logic [PC_W-1:0]   rd_instr;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output wb_valid, wb_pc, wb_instr, wb_data, wb_halt, rd_ready,
        input  rd_valid, rd_cyc, rd_pc, rd_instr, rd_data
    );

    modport slave (
        input  wb_valid, wb_pc, wb_instr, wb_data, wb_halt, rd_ready,
        output rd_valid, rd_cyc, rd_pc, rd_instr, rd_data
    );
endinterface

// File: rtl/commit_trace_buffer.sv
// Retirement trace recorder: captures writeback-stage retirements into a circular
// buffer (wrap / stop-when-full / PC trigger), then drains the frozen trace oldest-first.
module commit_trace_buffer #(
    parameter int DEPTH  = 16,
    parameter int PC_W   = 16,
    parameter int DATA_W = 16,
    parameter int CYC_W  = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    commit_trace_if.slave   trace,
    input  logic [1:0]      cfg_mode,
    input  logic [PC_W-1:0] trig_pc,
    input  logic [CW-1:0]   post_cnt,
    input  logic            arm,
    input  logic            flush,
    output logic [CW-1:0]   count,
    output logic            overflow,
    output logic            triggered,
    output logic [1:0]      state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        POST    = 2'd2,
        FROZEN  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        M_WRAP      = 2'd0,
        M_STOP_FULL = 2'd1,
        M_TRIGGER   = 2'd2
    } mode_e;

    typedef struct packed {
        logic [CYC_W-1:0]  cyc;
        logic [PC_W-1:0]   pc;
        logic [PC_W-1:0]   instr;
        logic [DATA_W-1:0] data;
    } entry_t;

    state_e            state_q, state_d;
    mode_e             mode_q, mode_d;
    logic [PC_W-1:0]   trig_pc_q, trig_pc_d;
    logic [CW-1:0]     post_cnt_q, post_cnt_d;
    logic [CW-1:0]     post_left_q, post_left_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              triggered_q, triggered_d;
    logic [CYC_W-1:0]  cyc_q;
    logic              wr_en;
    logic              full;
    logic              pc_match;
    logic [AW-1:0]     rd_ptr;
    logic              rd_valid;
    entry_t            rd_entry;
    entry_t            mem [DEPTH];

    assign full     = (count_q == CW'(DEPTH));
    assign pc_match = (mode_q == M_TRIGGER) && (trace.wb_pc == trig_pc_q);

    // NOTE: every variable written here gets a default first, so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        trig_pc_d   = trig_pc_q;
        post_cnt_d  = post_cnt_q;
        post_left_d = post_left_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        triggered_d = triggered_q;
        wr_en       = 1'b0;

        if (flush) begin
            state_d     = IDLE;
            count_d     = '0;
            wr_ptr_d    = '0;
            overflow_d  = 1'b0;
            triggered_d = 1'b0;
        end else if (arm && (state_q == IDLE || state_q == FROZEN)) begin
            state_d     = CAPTURE;
            count_d     = '0;
            wr_ptr_d    = '0;
            overflow_d  = 1'b0;
            triggered_d = 1'b0;
            post_left_d = '0;
            mode_d      = (cfg_mode == 2'd3) ? M_WRAP : mode_e'(cfg_mode);
            trig_pc_d   = trig_pc;
            post_cnt_d  = post_cnt;
        end else begin
            case (state_q)
                CAPTURE, POST: begin
                    if (trace.wb_valid) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        // A full buffer overwrites its oldest entry; count saturates.
                        if (full) overflow_d = 1'b1;
                        else      count_d    = count_q + 1'b1;

                        if (state_q == CAPTURE && pc_match) triggered_d = 1'b1;

                        if (trace.wb_halt) begin
                            state_d = FROZEN;
                        end else if (state_q == CAPTURE) begin
                            if (mode_q == M_STOP_FULL && count_q == CW'(DEPTH - 1)) begin
                                state_d = FROZEN;
                            end else if (pc_match) begin
                                if (post_cnt_q == '0) begin
                                    state_d = FROZEN;
                                end else begin
                                    post_left_d = post_cnt_q;
                                    state_d     = POST;
                                end
                            end
                        end else begin
                            post_left_d = post_left_q - 1'b1;
                            if (post_left_q == CW'(1)) state_d = FROZEN;
                        end
                    end
                end
                FROZEN: begin
                    if (count_q == '0) begin
                        state_d = IDLE;
                    end else if (trace.rd_ready) begin
                        count_d = count_q - 1'b1;
                        if (count_q == CW'(1)) state_d = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mode_q      <= M_WRAP;
            trig_pc_q   <= '0;
            post_cnt_q  <= '0;
            post_left_q <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            triggered_q <= 1'b0;
            cyc_q       <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            trig_pc_q   <= trig_pc_d;
            post_cnt_q  <= post_cnt_d;
            post_left_q <= post_left_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            triggered_q <= triggered_d;
            cyc_q       <= cyc_q + 1'b1;
        end
    end

    // NOTE: the trace array has no reset; count and state gate every read of it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= '{cyc:   cyc_q,
                               pc:    trace.wb_pc,
                               instr: trace.wb_instr,
                               data:  trace.wb_data};
        end
    end

    // Oldest entry sits count places behind the write pointer.
    assign rd_ptr   = wr_ptr_q - count_q[AW-1:0];
    assign rd_valid = (state_q == FROZEN) && (count_q != '0);
    assign rd_entry = mem[rd_ptr];

    assign trace.rd_valid = rd_valid;
    assign trace.rd_cyc   = rd_valid ? rd_entry.cyc   : '0;
    assign trace.rd_pc    = rd_valid ? rd_entry.pc    : '0;
    assign trace.rd_instr = rd_valid ? rd_entry.instr : '0;
    assign trace.rd_data  = rd_valid ? rd_entry.data  : '0;

    assign count     = count_q;
    assign overflow  = overflow_q;
    assign triggered = triggered_q;
    assign state     = state_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Self-checking bench for commit_trace_buffer (DEPTH=4): directed table, corner
// sequences, and randomized traffic against a queue-based trace model.
module tb_commit_trace_buffer;
    localparam int DEPTH  = 4;
    localparam int PC_W   = 16;
    localparam int DATA_W = 16;
    localparam int CYC_W  = 16;
    localparam int CW     = $clog2(DEPTH) + 1;

    localparam int S_IDLE = 0, S_CAPTURE = 1, S_POST = 2, S_FROZEN = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    commit_trace_if #(.PC_W(PC_W), .DATA_W(DATA_W), .CYC_W(CYC_W)) tif ();

    logic [1:0]      cfg_mode;
    logic [PC_W-1:0] trig_pc;
    logic [CW-1:0]   post_cnt;
    logic            arm;
    logic            flush;
    logic [CW-1:0]   count;
    logic            overflow;
    logic            triggered;
    logic [1:0]      state;

    commit_trace_buffer #(
        .DEPTH(DEPTH), .PC_W(PC_W), .DATA_W(DATA_W), .CYC_W(CYC_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .trace     (tif.slave),
        .cfg_mode  (cfg_mode),
        .trig_pc   (trig_pc),
        .post_cnt  (post_cnt),
        .arm       (arm),
        .flush     (flush),
        .count     (count),
        .overflow  (overflow),
        .triggered (triggered),
        .state     (state)
    );

    typedef struct {
        logic            wb_valid;
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] instr;
        logic [DATA_W-1:0] data;
        logic            halt;
        logic [1:0]      mode;
        logic [PC_W-1:0] tpc;
        logic [CW-1:0]   pcnt;
        logic            arm;
        logic            flush;
        logic            rd_ready;
    } in_t;

    typedef struct {
        logic [CYC_W-1:0]  cyc;
        logic [PC_W-1:0]   pc;
        logic [PC_W-1:0]   instr;
        logic [DATA_W-1:0] data;
    } ent_t;

    typedef struct {
        in_t             i;
        int              e_state;
        int              e_count;
        logic            e_valid;
        logic [PC_W-1:0] e_pc;
        logic            e_ovf;
    } vec_t;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Trace model: a bounded queue of retirements plus the capture phase.
    ent_t             mq[$];
    int               m_state;
    logic             m_ovf, m_trg;
    int               m_mode, m_pcnt, m_left;
    logic [PC_W-1:0]  m_tpc;
    logic [CYC_W-1:0] m_cyc;

    function automatic void model_reset();
        mq.delete();
        m_state = S_IDLE;
        m_ovf = 1'b0; m_trg = 1'b0;
        m_mode = 0; m_pcnt = 0; m_left = 0;
        m_tpc = '0; m_cyc = '0;
    endfunction

    function automatic void model_edge(input in_t i);
        ent_t e;
        logic match;
        if (i.flush) begin
            mq.delete(); m_ovf = 1'b0; m_trg = 1'b0; m_state = S_IDLE;
        end else if (i.arm && (m_state == S_IDLE || m_state == S_FROZEN)) begin
            mq.delete(); m_ovf = 1'b0; m_trg = 1'b0; m_state = S_CAPTURE;
            m_mode = (i.mode == 2'd3) ? 0 : int'(i.mode);
            m_tpc = i.tpc; m_pcnt = int'(i.pcnt);
        end else if ((m_state == S_CAPTURE || m_state == S_POST) && i.wb_valid) begin
            e.cyc = m_cyc; e.pc = i.pc; e.instr = i.instr; e.data = i.data;
            mq.push_back(e);
            if (mq.size() > DEPTH) begin
                void'(mq.pop_front());
                m_ovf = 1'b1;
            end
            match = (m_state == S_CAPTURE) && (m_mode == 2) && (i.pc == m_tpc);
            if (match) m_trg = 1'b1;
            if (i.halt) m_state = S_FROZEN;
            else if (m_state == S_CAPTURE) begin
                if (m_mode == 1 && mq.size() == DEPTH) m_state = S_FROZEN;
                else if (match) begin
                    if (m_pcnt == 0) m_state = S_FROZEN;
                    else begin m_left = m_pcnt; m_state = S_POST; end
                end
            end else begin
                m_left--;
                if (m_left == 0) m_state = S_FROZEN;
            end
        end else if (m_state == S_FROZEN) begin
            if (mq.size() == 0) m_state = S_IDLE;
            else if (i.rd_ready) begin
                void'(mq.pop_front());
                if (mq.size() == 0) m_state = S_IDLE;
            end
        end
        m_cyc = m_cyc + 1'b1;
    endfunction

    task automatic model_compare();
        logic ev;
        ent_t e;
        ev = (m_state == S_FROZEN) && (mq.size() > 0);
        e = '{default: '0};
        if (ev) e = mq[0];
        check("model.state",     state,        m_state);
        check("model.count",     count,        mq.size());
        check("model.overflow",  overflow,     m_ovf);
        check("model.triggered", triggered,    m_trg);
        check("model.rd_valid",  tif.rd_valid, ev);
        check("model.rd_cyc",    tif.rd_cyc,   e.cyc);
        check("model.rd_pc",     tif.rd_pc,    e.pc);
        check("model.rd_instr",  tif.rd_instr, e.instr);
        check("model.rd_data",   tif.rd_data,  e.data);
    endtask

    task automatic drive(input in_t i);
        tif.wb_valid = i.wb_valid; tif.wb_pc = i.pc; tif.wb_instr = i.instr;
        tif.wb_data = i.data; tif.wb_halt = i.halt; tif.rd_ready = i.rd_ready;
        cfg_mode = i.mode; trig_pc = i.tpc; post_cnt = i.pcnt;
        arm = i.arm; flush = i.flush;
    endtask

    task automatic step(input in_t i);
        drive(i);
        @(posedge clk);
        model_edge(i);
        #1;
        model_compare();
    endtask

    function automatic in_t idle_in();
        in_t i;
        i = '{default: '0};
        return i;
    endfunction

    function automatic in_t retire(input logic [PC_W-1:0] pc, input logic halt);
        in_t i;
        i = idle_in();
        i.wb_valid = 1'b1; i.pc = pc; i.halt = halt;
        i.instr = pc ^ 16'hA5A5;
        i.data = 16'($urandom);
        return i;
    endfunction

    function automatic in_t arm_in(input logic [1:0] mode, input logic [PC_W-1:0] tpc,
                                   input logic [CW-1:0] pcnt);
        in_t i;
        i = idle_in();
        i.arm = 1'b1; i.mode = mode; i.tpc = tpc; i.pcnt = pcnt;
        return i;
    endfunction

    function automatic in_t ready_in();
        in_t i;
        i = idle_in();
        i.rd_ready = 1'b1;
        return i;
    endfunction

    vec_t vecs[$];

    function automatic void add_vec(input in_t i, input int st, input int cnt, input logic v,
                                    input logic [PC_W-1:0] pc, input logic ovf);
        vec_t x;
        x.i = i; x.e_state = st; x.e_count = cnt; x.e_valid = v; x.e_pc = pc; x.e_ovf = ovf;
        vecs.push_back(x);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        in_t r;
        logic [PC_W-1:0] hold_pc, hold_instr, hold_data;
        logic [CYC_W-1:0] hold_cyc;
        logic [PC_W-1:0] got_pc[$];
        logic [CYC_W-1:0] got_cyc[$];
        logic prev_stall;
        logic [PC_W-1:0] prev_pc;
        logic [CYC_W-1:0] prev_cyc;
        logic [PC_W-1:0] exp_trig[4];
        int budget;

        drive(idle_in());
        model_reset();
        #12;
        check("reset.state",    state,        0);
        check("reset.count",    count,        0);
        check("reset.overflow", overflow,     0);
        check("reset.rd_valid", tif.rd_valid, 0);
        check("reset.rd_pc",    tif.rd_pc,    0);
        @(negedge clk);
        rst_n = 1'b1;

        // WRAP: 7 retires then HLT, drain keeps the last four.
        add_vec(arm_in(2'd0, '0, '0), S_CAPTURE, 0, 1'b0, 16'h0000, 1'b0);
        for (int k = 0; k < 7; k++)
            add_vec(retire(16'(2 * k), 1'b0), S_CAPTURE, (k < 4) ? k + 1 : 4, 1'b0, 16'h0000, k >= 4);
        add_vec(retire(16'h000E, 1'b1), S_FROZEN, 4, 1'b1, 16'h0008, 1'b1);
        add_vec(ready_in(), S_FROZEN, 3, 1'b1, 16'h000A, 1'b1);
        add_vec(ready_in(), S_FROZEN, 2, 1'b1, 16'h000C, 1'b1);
        add_vec(ready_in(), S_FROZEN, 1, 1'b1, 16'h000E, 1'b1);
        add_vec(ready_in(), S_IDLE,   0, 1'b0, 16'h0000, 1'b1);
        for (int k = 0; k < vecs.size(); k++) begin
            step(vecs[k].i);
            check($sformatf("vec%0d.state", k),    state,        vecs[k].e_state);
            check($sformatf("vec%0d.count", k),    count,        vecs[k].e_count);
            check($sformatf("vec%0d.rd_valid", k), tif.rd_valid, vecs[k].e_valid);
            check($sformatf("vec%0d.rd_pc", k),    tif.rd_pc,    vecs[k].e_pc);
            check($sformatf("vec%0d.overflow", k), overflow,     vecs[k].e_ovf);
        end

        // STOP_FULL: freezes on the 4th retire, later retires ignored.
        step(arm_in(2'd1, '0, '0));
        for (int k = 0; k < 6; k++) begin
            step(retire(16'(16'h0100 + 2 * k), 1'b0));
            if (k == 2) check("sf.capture_at_3", state, S_CAPTURE);
            if (k == 3) check("sf.frozen_at_4", state, S_FROZEN);
        end
        check("sf.overflow", overflow, 0);
        check("sf.count", count, 4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("sf.drain%0d", k), tif.rd_pc, 16'(16'h0100 + 2 * k));
            step(ready_in());
        end
        check("sf.idle", state, S_IDLE);

        // TRIGGER at 0x0010 with two post entries, then a stalled/toggled drain.
        step(arm_in(2'd2, 16'h0010, 3'd2));
        for (int pc = 0; pc <= 16'h20; pc += 2) begin
            step(retire(16'(pc), 1'b0));
            if (pc == 16'h12) check("trig.post_before_14", state, S_POST);
            if (pc == 16'h14) check("trig.frozen_at_14", state, S_FROZEN);
        end
        check("trig.triggered", triggered, 1);
        hold_pc = tif.rd_pc; hold_cyc = tif.rd_cyc;
        hold_instr = tif.rd_instr; hold_data = tif.rd_data;
        for (int k = 0; k < 3; k++) begin
            step(idle_in());
            check("stall.rd_pc",    tif.rd_pc,    hold_pc);
            check("stall.rd_cyc",   tif.rd_cyc,   hold_cyc);
            check("stall.rd_instr", tif.rd_instr, hold_instr);
            check("stall.rd_data",  tif.rd_data,  hold_data);
            check("stall.rd_valid", tif.rd_valid, 1);
        end
        prev_stall = 1'b0; prev_pc = '0; prev_cyc = '0;
        budget = 0;
        while (state == S_FROZEN && budget < 20) begin
            r = idle_in();
            r.rd_ready = budget[0];
            if (prev_stall) begin
                check("toggle.stable_pc",  tif.rd_pc,  prev_pc);
                check("toggle.stable_cyc", tif.rd_cyc, prev_cyc);
            end
            prev_stall = tif.rd_valid && !r.rd_ready;
            prev_pc = tif.rd_pc; prev_cyc = tif.rd_cyc;
            if (tif.rd_valid && r.rd_ready) begin
                got_pc.push_back(tif.rd_pc);
                got_cyc.push_back(tif.rd_cyc);
            end
            step(r);
            budget++;
        end
        check("trig.drain_done", state, S_IDLE);
        check("trig.delivered", got_pc.size(), 4);
        exp_trig[0] = 16'h000E; exp_trig[1] = 16'h0010;
        exp_trig[2] = 16'h0012; exp_trig[3] = 16'h0014;
        for (int k = 0; k < 4 && k < got_pc.size(); k++)
            check($sformatf("trig.pc%0d", k), got_pc[k], exp_trig[k]);
        for (int k = 1; k < got_cyc.size(); k++)
            check($sformatf("trig.cyc_incr%0d", k), got_cyc[k] > got_cyc[k-1], 1);

        // flush together with arm mid-CAPTURE: flush wins, nothing written.
        step(arm_in(2'd0, '0, '0));
        step(retire(16'h0040, 1'b0));
        step(retire(16'h0042, 1'b0));
        r = retire(16'h0044, 1'b0);
        r.arm = 1'b1; r.flush = 1'b1;
        step(r);
        check("flush.state", state, S_IDLE);
        check("flush.count", count, 0);

        // Asynchronous reset in the middle of POST.
        step(arm_in(2'd2, 16'h0050, 3'd3));
        step(retire(16'h004E, 1'b0));
        step(retire(16'h0050, 1'b0));
        check("post.entered", state, S_POST);
        step(retire(16'h0052, 1'b0));
        #2;
        rst_n = 1'b0;
        #1;
        check("areset.state",     state,        0);
        check("areset.count",     count,        0);
        check("areset.overflow",  overflow,     0);
        check("areset.triggered", triggered,    0);
        check("areset.rd_valid",  tif.rd_valid, 0);
        check("areset.rd_pc",     tif.rd_pc,    0);
        check("areset.rd_cyc",    tif.rd_cyc,   0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // HLT on the trigger-match cycle freezes at once, trigger still recorded.
        step(arm_in(2'd2, 16'h0060, 3'd3));
        step(retire(16'h005E, 1'b0));
        step(retire(16'h0060, 1'b1));
        check("halt_trig.frozen", state, S_FROZEN);
        check("halt_trig.triggered", triggered, 1);
        check("halt_trig.count", count, 2);
        budget = 0;
        while (state != S_IDLE && budget < 10) begin
            step(ready_in());
            budget++;
        end
        check("halt_trig.drained", state, S_IDLE);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            r = idle_in();
            r.wb_valid = ($urandom_range(0, 9) < 6);
            r.pc       = 16'($urandom_range(0, 7) * 2);
            r.instr    = 16'($urandom);
            r.data     = 16'($urandom);
            r.halt     = ($urandom_range(0, 39) == 0);
            r.mode     = 2'($urandom_range(0, 3));
            r.tpc      = 16'($urandom_range(0, 7) * 2);
            r.pcnt     = CW'($urandom_range(0, DEPTH + 1));
            r.arm      = (m_state == S_IDLE) ? ($urandom_range(0, 3) == 0)
                                             : ($urandom_range(0, 40) == 0);
            r.flush    = ($urandom_range(0, 199) == 0);
            r.rd_ready = 1'($urandom_range(0, 1));
            step(r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
